// File: rtl/irq_aggregator.sv
// Six-source interrupt aggregator: per-source synchroniser, edge/level pending latch,
// mask, and a registered HWInt vector behind a small bridge-addressed register window.
module irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic clr,
  output logic pending
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev <= sync;
      // Edge: a fresh rising edge beats a same-cycle clear. Level: track sync.
      if (mode) pending <= (sync & ~prev) | (pending & ~clr);
      else      pending <= sync;
    end
  end
endmodule

module irq_aggregator #(
  parameter logic [31:0] BASE        = 32'h0000_7F40,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [5:0]  irq_src,
  output logic [5:0]  HWInt,
  output logic        IRQ
);
  localparam int          NUM_LANES = 6;
  localparam logic [29:0] BASE_W    = BASE[31:2];
  localparam logic [2:0]  OFF_PEND  = 3'd0;
  localparam logic [2:0]  OFF_MASK  = 3'd1;
  localparam logic [2:0]  OFF_MODE  = 3'd2;
  localparam logic [2:0]  OFF_CLR   = 3'd3;
  localparam logic [2:0]  OFF_ACT   = 3'd4;
  localparam logic [2:0]  OFF_HI    = 3'd5;

  logic [NUM_LANES-1:0] pending, mask, mode, active, clr_vec;
  logic [29:0]          rel;
  logic [2:0]           off;
  logic                 in_win;
  logic [2:0]           hi_idx;
  logic                 unused_din;

  // Word offset into the window; addresses below BASE wrap high and fall out.
  assign rel        = Addr - BASE_W;
  assign in_win     = (Addr >= BASE_W) && (rel < 30'd6);
  assign off        = rel[2:0];
  assign clr_vec    = (WE && in_win && off == OFF_CLR) ? Din[NUM_LANES-1:0] : '0;
  assign active     = pending & mask;
  assign unused_din = ^Din[31:NUM_LANES];

  irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [NUM_LANES-1:0] (
    .clk     (clk),
    .reset   (reset),
    .src     (irq_src),
    .mode    (mode),
    .clr     (clr_vec),
    .pending (pending)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask  <= '0;
      mode  <= '0;
      HWInt <= '0;
    end else begin
      if (WE && in_win && off == OFF_MASK) mask <= Din[NUM_LANES-1:0];
      if (WE && in_win && off == OFF_MODE) mode <= Din[NUM_LANES-1:0];
      HWInt <= active;
    end
  end

  assign IRQ = |HWInt;

  // Scan high-to-low so the lowest-numbered active source is the one left standing.
  always_comb begin
    hi_idx = 3'd0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (active[i]) hi_idx = 3'(i);
  end

  always_comb begin
    Dout = '0;
    if (in_win) begin
      case (off)
        OFF_PEND: Dout = {26'b0, pending};
        OFF_MASK: Dout = {26'b0, mask};
        OFF_MODE: Dout = {26'b0, mode};
        OFF_ACT:  Dout = {26'b0, active};
        OFF_HI:   Dout = {|active, 28'b0, hi_idx};
        default:  Dout = '0;
      endcase
    end
  end
endmodule

// File: doc/irq_aggregator.md
Name: irq_aggregator

Overview:
Memory-mapped interrupt aggregator on the Bridge peripheral bus, sitting directly upstream of the CPU's HWInt input. It collects the six hardware interrupt sources: Timer1 IRQ, Timer2 IRQ, the external interrupt pin and three spares. Each source is synchronised, latched as edge- or level-sensitive, masked, and presented as a registered HWInt[5:0] vector. Software reads pending state and acknowledges edge interrupts through bridge-addressed registers.

Parameters:
BASE, 32'h0000_7F40, word-aligned base address of the register window (24 bytes, offsets 0x00-0x14).
SYNC_STAGES, 2, flip-flop depth of the input synchroniser; legal values are 1 to 3.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on clk rising edge, asserted when 0.
Addr  input  30  word address [31:2] from bridge.
WE  input  1  write enable from bridge.
Din  input  32  write data.
Dout  output  32  read data, combinational from Addr.
irq_src  input  6  raw interrupt sources; bit0 Timer1, bit1 Timer2, bit2 external, bits5:3 spare.
HWInt  output  6  registered masked-pending vector to CPU.
IRQ  output  1  OR-reduction of HWInt.

Behaviour:
- Register map, offset from BASE:
  - 0x00 PENDING: RO, pending[5:0].
  - 0x04 MASK: RW, mask[5:0].
  - 0x08 MODE: RW, bit=1 edge, bit=0 level.
  - 0x0C CLEAR: WO, write-1-to-clear of pending; reads 0.
  - 0x10 ACTIVE: RO, pending&mask.
  - 0x14 HIGHEST: RO, bit31 = any active, bits2:0 = lowest-numbered active index; all 0 if none.
- Upper register bits read 0. Unmapped offsets and addresses outside the window read 0. Writes to RO offsets are ignored.
- A write happens only when WE=1 and Addr selects a writable offset. It takes effect at that clk edge.
- Synchroniser: SYNC_STAGES-deep per bit. sync = last stage. prev = sync delayed one cycle.
- Edge mode: pending[i] is set when sync[i]=1 and prev[i]=0. It stays set until cleared through CLEAR.
- Set/clear collision: if a set event and a CLEAR write to the same bit fall on the same edge, set wins and pending stays 1.
- Level mode: pending[i] follows sync[i] each cycle. CLEAR has no effect on level bits.
- MODE change: switching a bit from level to edge keeps its current pending value. Switching from edge to level overwrites it from sync next edge.
- HWInt is registered: HWInt <= pending & mask on every edge.
- Latency with SYNC_STAGES=2: irq_src rises before edge E0. sync=1 after E1, pending=1 after E2, HWInt=1 after E3. In general HWInt follows SYNC_STAGES+2 edges after the first sampling edge.
- MASK write at edge W is reflected in HWInt after edge W+1. CLEAR follows the same timing.
- IRQ is combinational |HWInt; it carries no additional latency.
- Reset (reset==0 at an edge): synchroniser, prev, pending, mask, mode and HWInt all go to 0. Dout then reads 0 for PENDING/MASK/MODE/ACTIVE/HIGHEST.
- Reset mid-pulse aborts any pending and in-flight synchroniser state.
- Source held high across reset release: treated as a fresh rising edge. Pending sets SYNC_STAGES+1 edges after the first non-reset edge.
- Multiple sources may set on the same edge; each bit is independent.

Test Plan:
1. Reset: reset=0 for 2 cycles with irq_src=6'h3F, then release with irq_src=0 -> HWInt=0, IRQ=0; reads of 0x00/0x04/0x08 return 0.
2. Edge latency: write MASK=0x07, MODE=0x07, then pulse irq_src[1] high 1 cycle before E0 -> PENDING=0x02 after E2; HWInt=6'h02 and IRQ=1 after E3; HIGHEST=0x8000_0001.
3. W1C and collision: pending=0x03; write CLEAR=0x01 -> PENDING=0x02 next edge; HWInt drops bit0 one edge later. Then CLEAR=0x02 on the same edge bit1 sees a new rising edge -> PENDING bit1 stays 1.
4. Level mode: MODE=0, MASK=0x04, hold irq_src[2]=1 -> HWInt=0x04 after 4 edges. Write CLEAR=0x04 -> no change. Drop irq_src[2] -> HWInt=0 after 4 edges.
5. Masking and priority: irq_src=0x05 edge mode, MASK=0x04 -> HWInt=0x04, ACTIVE=0x04, HIGHEST=0x8000_0002. Write MASK=0x05 at edge W -> HWInt=0x05 after W+1, HIGHEST=0x8000_0000.
6. Address decode: write 0xFFFF_FFFF to BASE+0x00 and BASE+0x18, and to BASE-4 -> no state change; Dout at BASE+0x18 reads 0; WE=0 writes to MASK are ignored.
